// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the architectural register file.
// Register indexing, word width and the hard-wired zero register.
package register_file_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_ID_W  = 5;
    localparam int XLEN      = 32;

    localparam logic [REG_ID_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [XLEN-1:0]     word_t;

    // x0 is hard-wired: never renamed, never written, always reads zero
    function automatic logic is_zero_reg(input reg_id_t id);
        return id == ZERO_REG;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port.
// Looks up value/busy/tag and forwards a matching same-cycle commit.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH = 4
) (
    input  logic                                 rdy_in,
    input  logic                                 rst_in,
    input  logic [REG_ID_W-1:0]                  rs_id,
    input  logic [REG_COUNT-1:0]                 busy_q,
    input  logic [REG_COUNT-1:0][ROB_WIDTH-1:0]  tag_q,
    input  logic [REG_COUNT-1:0][XLEN-1:0]       val_q,
    input  logic                                 cm_ready,
    input  logic [REG_ID_W-1:0]                  cm_reg_id,
    input  logic [XLEN-1:0]                      cm_reg_val,
    input  logic [ROB_WIDTH-1:0]                 cm_rob_idx,
    output logic                                 rs_busy,
    output logic [ROB_WIDTH-1:0]                 rs_depend,
    output logic [XLEN-1:0]                      rs_val
);

    logic                 hit_busy;
    logic [ROB_WIDTH-1:0] hit_tag;
    logic [XLEN-1:0]      hit_val;
    logic                 bypass;

    // Raw lookup of the addressed entry
    always_comb begin
        hit_busy = busy_q[rs_id];
        hit_tag  = tag_q[rs_id];
        hit_val  = val_q[rs_id];
    end

    // A commit releasing exactly the rename we see is forwarded now
    always_comb begin
        bypass = rdy_in && !rst_in && cm_ready
              && !is_zero_reg(rs_id) && hit_busy
              && (cm_reg_id == rs_id)
              && (cm_rob_idx == hit_tag);
    end

    // Select stored state, forwarded commit, or the zero register
    always_comb begin
        rs_busy   = hit_busy;
        rs_depend = hit_tag;
        rs_val    = hit_val;
        if (is_zero_reg(rs_id)) begin
            rs_busy   = 1'b0;
            rs_depend = '0;
            rs_val    = '0;
        end else if (bypass) begin
            rs_busy = 1'b0;
            rs_val  = cm_reg_val;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Issue renames rd; ROB commit writes and releases matching renames.
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,
    input  logic [4:0]           iu_to_rf_rs1_id,
    output logic                 rf_to_iu_rs1_busy,
    output logic [ROB_WIDTH-1:0] rf_to_iu_rs1_depend,
    output logic [31:0]          rf_to_iu_val1,
    input  logic [4:0]           iu_to_rf_rs2_id,
    output logic                 rf_to_iu_rs2_busy,
    output logic [ROB_WIDTH-1:0] rf_to_iu_rs2_depend,
    output logic [31:0]          rf_to_iu_val2,
    input  logic                 issue_ready,
    input  logic [4:0]           issue_rd_id,
    input  logic [ROB_WIDTH-1:0] issue_rob_idx,
    input  logic                 rob_to_rf_ready,
    input  logic [4:0]           rob_to_rf_reg_id,
    input  logic [31:0]          rob_to_rf_reg_val,
    input  logic [ROB_WIDTH-1:0] rob_to_rf_rob_idx
);

    logic [REG_COUNT-1:0]                busy_q;
    logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tag_q;
    logic [REG_COUNT-1:0][XLEN-1:0]      val_q;

    logic commit_en;
    logic release_en;
    logic issue_en;

    // Qualify the commit and issue streams (x0 is never touched)
    always_comb begin
        commit_en  = rob_to_rf_ready && !is_zero_reg(rob_to_rf_reg_id);
        release_en = commit_en
                  && busy_q[rob_to_rf_reg_id]
                  && (tag_q[rob_to_rf_reg_id] == rob_to_rf_rob_idx);
        issue_en   = issue_ready && !clr_in && !is_zero_reg(issue_rd_id);
    end

    // State update: commit first, then flush, then issue (issue wins)
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            tag_q  <= '0;
            val_q  <= '0;
        end else if (rdy_in) begin
            if (commit_en) begin
                val_q[rob_to_rf_reg_id] <= rob_to_rf_reg_val;
            end
            if (release_en) begin
                busy_q[rob_to_rf_reg_id] <= 1'b0;
            end
            if (clr_in) begin
                busy_q <= '0;
            end else if (issue_en) begin
                busy_q[issue_rd_id] <= 1'b1;
                tag_q[issue_rd_id]  <= issue_rob_idx;
            end
        end
    end

    rf_read_port #(
        .ROB_WIDTH (ROB_WIDTH)
    ) u_rs1 (
        .rdy_in     (rdy_in),
        .rst_in     (rst_in),
        .rs_id      (iu_to_rf_rs1_id),
        .busy_q     (busy_q),
        .tag_q      (tag_q),
        .val_q      (val_q),
        .cm_ready   (rob_to_rf_ready),
        .cm_reg_id  (rob_to_rf_reg_id),
        .cm_reg_val (rob_to_rf_reg_val),
        .cm_rob_idx (rob_to_rf_rob_idx),
        .rs_busy    (rf_to_iu_rs1_busy),
        .rs_depend  (rf_to_iu_rs1_depend),
        .rs_val     (rf_to_iu_val1)
    );

    rf_read_port #(
        .ROB_WIDTH (ROB_WIDTH)
    ) u_rs2 (
        .rdy_in     (rdy_in),
        .rst_in     (rst_in),
        .rs_id      (iu_to_rf_rs2_id),
        .busy_q     (busy_q),
        .tag_q      (tag_q),
        .val_q      (val_q),
        .cm_ready   (rob_to_rf_ready),
        .cm_reg_id  (rob_to_rf_reg_id),
        .cm_reg_val (rob_to_rf_reg_val),
        .cm_rob_idx (rob_to_rf_rob_idx),
        .rs_busy    (rf_to_iu_rs2_busy),
        .rs_depend  (rf_to_iu_rs2_depend),
        .rs_val     (rf_to_iu_val2)
    );

endmodule
